// File: rtl/uart_cmd_assembler.sv
// ---------------------------------------------------------------------------
// uart_cmd_assembler
//
// Packs NUM_BYTES consecutive bytes from the UART byte receiver, MSB-first,
// into one CMD_W-bit command word and presents it to the command decoder.
// A stale partial command is dropped after TIMEOUT_CYC idle cycles so the
// byte stream can resynchronise.
//
// Optional feature macro: UART_CMD_OVERRUN_EN
//   defined   : bytes arriving while a command is held are consumed and
//               dropped, and the sticky overrun flag is raised.
//   undefined : a held command back-pressures the receiver; overrun is 0.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst          in   1      synchronous active-high reset
//   rx_data      in   8      byte from receiver, valid while rx_rdy=1
//   rx_rdy       in   1      receiver byte-ready
//   clr_rx_rdy   out  1      combinational byte-accept strobe to receiver
//   cmd          out  CMD_W  assembled command, first byte in the MSBs
//   cmd_rdy      out  1      command valid, held until clr_cmd_rdy
//   clr_cmd_rdy  in   1      consumer acknowledge
//   timeout      out  1      one-cycle pulse when a partial command is dropped
//   overrun      out  1      sticky overrun flag
// ---------------------------------------------------------------------------
module uart_cmd_assembler #(
  parameter  int NUM_BYTES   = 2,
  parameter  int TIMEOUT_CYC = 26040,
  localparam int CMD_W       = 8 * NUM_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_rdy,
  output logic             clr_rx_rdy,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  output logic             timeout,
  output logic             overrun
);

  localparam int SH_W  = CMD_W - 8;               // bytes held before the last one
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam int CNT_W = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [SH_W-1:0]  shift;
  logic [CNT_W-1:0] byte_cnt;
  logic [TMR_W-1:0] timer;

  logic             accept;     // strobe returned to the receiver
  logic             take;       // accepted byte is actually stored
  logic             last;       // stored byte completes the command
  logic             tmo_hit;    // partial command expires this cycle
  logic [CMD_W-1:0] word_next;  // held bytes plus the incoming byte

  assign word_next = {shift, rx_data};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take) begin
          state_next = last ? HOLD : COLLECT;
        end else begin
          state_next = IDLE;
        end
      end
      COLLECT: begin
        if (take) begin
          state_next = last ? HOLD : COLLECT;
        end else if (tmo_hit) begin
          state_next = IDLE;
        end else begin
          state_next = COLLECT;
        end
      end
      HOLD: begin
        if (clr_cmd_rdy) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / handshake decode. Reset suppresses the accept strobe.
  always_comb begin
    accept = 1'b0;
    take   = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        accept = rx_rdy & ~rst;
        take   = rx_rdy & ~rst;
      end
      HOLD: begin
`ifdef UART_CMD_OVERRUN_EN
        // Byte is consumed but never stored.
        accept = rx_rdy & ~rst;
`else
        accept = 1'b0;
`endif
        take   = 1'b0;
      end
      default: begin
        accept = 1'b0;
        take   = 1'b0;
      end
    endcase
    last    = take & (byte_cnt == CNT_W'(NUM_BYTES - 1));
    // An accept on the final timer cycle wins over the timeout.
    tmo_hit = (state == COLLECT) & ~take & (timer == TMR_W'(TIMEOUT_CYC - 1));
  end

  assign clr_rx_rdy = accept;

  // Byte shift register, byte counter and inter-byte timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift    <= '0;
      byte_cnt <= '0;
      timer    <= '0;
    end else if (take) begin
      shift    <= word_next[SH_W-1:0];
      byte_cnt <= byte_cnt + CNT_W'(1);
      timer    <= '0;
    end else if (tmo_hit) begin
      shift    <= '0;
      byte_cnt <= '0;
      timer    <= '0;
    end else if (state == COLLECT) begin
      timer    <= timer + TMR_W'(1);
    end else if ((state == HOLD) && clr_cmd_rdy) begin
      byte_cnt <= '0;
      timer    <= '0;
    end else begin
      timer    <= '0;
    end
  end

  // Command word and ready flag; cmd keeps its value after acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else if (last) begin
      cmd     <= word_next;
      cmd_rdy <= 1'b1;
    end else if ((state == HOLD) && clr_cmd_rdy) begin
      cmd_rdy <= 1'b0;
    end else begin
      cmd_rdy <= cmd_rdy;
    end
  end

  // Timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout <= 1'b0;
    end else begin
      timeout <= tmo_hit;
    end
  end

  // Sticky overrun flag; acknowledge wins over a same-cycle overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else begin
`ifdef UART_CMD_OVERRUN_EN
      if ((state == HOLD) && clr_cmd_rdy) begin
        overrun <= 1'b0;
      end else if ((state == HOLD) && accept) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
`else
      overrun <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for uart_cmd_assembler (NUM_BYTES=2,
// TIMEOUT_CYC=100). Inputs are driven on the falling edge; outputs are
// sampled 1 ns later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_uart_cmd_assembler;

  localparam int NB    = 2;
  localparam int TMO   = 100;
  localparam int CMD_W = 8 * NB;

  logic             clk;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_rdy;
  logic             clr_rx_rdy;
  logic [CMD_W-1:0] cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             timeout;
  logic             overrun;

  int checks;
  int errors;

  uart_cmd_assembler #(.NUM_BYTES(NB), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (clr_rx_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a byte and hold it until accepted; returns just after the accept edge.
  task automatic send_byte(input string tag, input logic [7:0] b);
    logic got;
    got = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (clr_rx_rdy === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_accept"}, {31'd0, got}, 32'd1);
    @(negedge clk);
    rx_rdy = 1'b0;
    #1;
    check({tag, "_strobe_drop"}, {31'd0, clr_rx_rdy}, 32'd0);
  endtask

  // Acknowledge the held command.
  task automatic clear_cmd(input string tag);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    #1;
    check({tag, "_cmd_rdy_clr"}, {31'd0, cmd_rdy}, 32'd0);
  endtask

  // Advance n cycles; report whether any timeout pulse was seen.
  task automatic idle_cycles(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (timeout === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    rx_rdy      = 1'b1;
    rx_data     = 8'hFF;
    clr_cmd_rdy = 1'b0;

    // Reset with rx_rdy asserted.
    repeat (2) @(negedge clk);
    #1;
    check("rst_clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
    check("rst_cmd", {16'd0, cmd}, 32'h0000);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    rx_rdy = 1'b0;
    @(negedge clk);

    // Basic two-byte command.
    send_byte("b0", 8'hA5);
    check("b0_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    send_byte("b1", 8'h3C);
    check("a53c_cmd", {16'd0, cmd}, 32'h0000A53C);
    check("a53c_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

`ifdef UART_CMD_OVERRUN_EN
    // Byte arriving in HOLD is consumed and dropped.
    rx_data = 8'h77;
    rx_rdy  = 1'b1;
    #1;
    check("ovr_strobe", {31'd0, clr_rx_rdy}, 32'd1);
    @(negedge clk);
    rx_rdy = 1'b0;
    #1;
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_cmd", {16'd0, cmd}, 32'h0000A53C);
    check("ovr_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    clear_cmd("ovr");
    check("ovr_flag_clr", {31'd0, overrun}, 32'd0);
`else
    // Back-pressure: byte waits in the receiver while the command is held.
    rx_data = 8'h11;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_strobe", {31'd0, clr_rx_rdy}, 32'd0);
      @(negedge clk);
    end
    #1;
    check("bp_cmd", {16'd0, cmd}, 32'h0000A53C);
    check("bp_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("bp_overrun", {31'd0, overrun}, 32'd0);
    clr_cmd_rdy = 1'b1;
    #1;
    check("bp_strobe_ack", {31'd0, clr_rx_rdy}, 32'd0);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    #1;
    check("bp_cmd_rdy_clr", {31'd0, cmd_rdy}, 32'd0);
    check("bp_cmd_kept", {16'd0, cmd}, 32'h0000A53C);
    check("bp_strobe_next", {31'd0, clr_rx_rdy}, 32'd1);
    @(negedge clk);
    rx_rdy = 1'b0;
    send_byte("bp2", 8'h22);
    check("bp_cmd_1122", {16'd0, cmd}, 32'h00001122);
    clear_cmd("bp");
`endif

    // Timeout drops a stale partial command.
    send_byte("t0", 8'h55);
    idle_cycles(TMO - 1, seen);
    check("tmo_early", {31'd0, seen}, 32'd0);
    @(negedge clk);
    #1;
    check("tmo_pulse", {31'd0, timeout}, 32'd1);
    @(negedge clk);
    #1;
    check("tmo_pulse_end", {31'd0, timeout}, 32'd0);
    check("tmo_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    send_byte("t1", 8'h12);
    check("tmo_no_cmd", {31'd0, cmd_rdy}, 32'd0);
    send_byte("t2", 8'h34);
    check("tmo_cmd_1234", {16'd0, cmd}, 32'h00001234);
    check("tmo_cmd_rdy2", {31'd0, cmd_rdy}, 32'd1);
    clear_cmd("tmo");

    // Second byte lands on the final timer cycle: accept wins.
    send_byte("e0", 8'hAB);
    idle_cycles(TMO - 1, seen);
    check("edge_early", {31'd0, seen}, 32'd0);
    send_byte("e1", 8'hCD);
    check("edge_no_tmo", {31'd0, timeout}, 32'd0);
    check("edge_cmd", {16'd0, cmd}, 32'h0000ABCD);
    check("edge_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    @(negedge clk);
    #1;
    check("edge_no_tmo2", {31'd0, timeout}, 32'd0);
    clear_cmd("edge");

    // Reset in the middle of a command.
    send_byte("r0", 8'h99);
    rst     = 1'b1;
    rx_rdy  = 1'b1;
    rx_data = 8'hEE;
    #1;
    check("mid_rst_strobe", {31'd0, clr_rx_rdy}, 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    rx_rdy = 1'b0;
    #1;
    check("mid_rst_cmd", {16'd0, cmd}, 32'h0000);
    check("mid_rst_tmo", {31'd0, timeout}, 32'd0);
    send_byte("r1", 8'h01);
    check("mid_rst_partial", {31'd0, cmd_rdy}, 32'd0);
    send_byte("r2", 8'h02);
    check("mid_rst_cmd_0102", {16'd0, cmd}, 32'h00000102);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
Downstream consumer of the UART byte receiver. Accepts received bytes via the receiver's rdy/clr_rdy handshake and packs NUM_BYTES consecutive bytes, MSB-first, into one command word. Presents the word to the command decoder with a cmd_rdy/clr_cmd_rdy handshake. An inter-byte timeout discards stale partial commands so the byte stream resynchronises.

Parameters:
NUM_BYTES, 2, bytes per command; legal range 2..4; CMD_W = 8*NUM_BYTES.
TIMEOUT_CYC, 26040, clk cycles allowed between accepted bytes of one command; about 10 bit-times at 2604 clk/bit; minimum 4.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
rx_data  in  8  byte from UART receiver, valid while rx_rdy=1
rx_rdy  in  1  receiver byte-ready
clr_rx_rdy  out  1  combinational byte-accept strobe back to receiver
cmd  out  CMD_W  assembled command, first byte received in MSBs
cmd_rdy  out  1  command valid, held until cleared
clr_cmd_rdy  in  1  consumer acknowledge
timeout  out  1  one-cycle pulse when a partial command is discarded
overrun  out  1  sticky overrun flag; see Optional Feature

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). On reset: state=IDLE, byte_cnt=0, timer=0, cmd=0, cmd_rdy=0, timeout=0, overrun=0. clr_rx_rdy=0 while rst=1.
- States:
  - IDLE: no bytes held.
  - COLLECT: 1..NUM_BYTES-1 bytes held.
  - HOLD: full command presented.
- Accept condition: rx_rdy=1 and state is IDLE or COLLECT (and rst=0). clr_rx_rdy = accept; it is combinational and lasts exactly the accept cycle. The receiver drops rdy at the same edge, so no byte is captured twice.
- On accept: shift register <= {shift[CMD_W-9:0], rx_data}; byte_cnt+1; timer cleared.
  - If this is byte NUM_BYTES: the cmd register loads the completed word, cmd_rdy=1 and state=HOLD from the next cycle. Latency is 1 clk from the last accept edge.
  - Otherwise: IDLE->COLLECT, or stay in COLLECT.
- HOLD: cmd and cmd_rdy are stable. rx_rdy is not accepted (clr_rx_rdy=0) and the byte waits in the receiver.
  - clr_cmd_rdy=1: cmd_rdy=0, byte_cnt=0, state=IDLE at the next edge. cmd keeps its last value.
  - An rx_rdy present in the same cycle as clr_cmd_rdy is accepted in the following cycle.
  - clr_cmd_rdy outside HOLD is ignored.
- Timer (width ceil(log2(TIMEOUT_CYC))):
  - Increments each cycle in COLLECT without an accept. Held at 0 in IDLE and HOLD.
  - When timer == TIMEOUT_CYC-1 with no accept that cycle: next edge sets state=IDLE, byte_cnt=0, shift=0, and timeout=1 for one cycle.
  - An accept in that same cycle wins: no timeout, timer cleared.
- Reset mid-COLLECT or mid-HOLD discards everything and returns to IDLE. It generates no timeout pulse and no clr_rx_rdy.
- byte_cnt never exceeds NUM_BYTES. The shift register is overwritten per command; no wrap carry-over.

Optional Feature:
- Macro UART_CMD_OVERRUN_EN.
- Defined:
  - In HOLD, rx_rdy is accepted anyway: clr_rx_rdy=1, byte discarded, cmd unchanged, overrun set at the next edge.
  - overrun clears on clr_cmd_rdy or rst. If set and clear land in the same cycle, clear wins.
- Not defined: overrun tied 0, and HOLD back-pressures as described above.

Test Plan:
- Reset: rst=1 for 2 cycles with rx_rdy=1 -> cmd=0, cmd_rdy=0, clr_rx_rdy=0, timeout=0.
- NUM_BYTES=2: bytes 0xA5 then 0x3C, each rx_rdy held until clr_rx_rdy -> clr_rx_rdy high exactly 1 cycle per byte; cmd=0xA53C and cmd_rdy=1 one cycle after the second accept.
- Back-pressure (macro off): in HOLD, present 0x11 -> clr_rx_rdy stays 0 and cmd stays 0xA53C. Pulse clr_cmd_rdy -> cmd_rdy=0; 0x11 accepted the next cycle.
- Timeout, TIMEOUT_CYC=100: send 0x55, then idle 100 cycles -> timeout pulses 1 cycle and state=IDLE. Then 0x12, 0x34 -> cmd=0x1234, not 0x5512.
- Timeout boundary: second byte accepted on the timer==99 cycle -> no timeout pulse; cmd completes normally.
- UART_CMD_OVERRUN_EN defined: in HOLD send 0x77 -> clr_rx_rdy=1, overrun=1, cmd unchanged. clr_cmd_rdy -> overrun=0.
